// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch; owns the PC, runs one imem req/ack at a
// time and buffers fetched words in a QDEPTH-entry queue for Decode.
// Ports: clk, rst (sync, active-low); imem_req/addr/ack/rdata fetch port;
// stall, branch_taken/branch_target control; inst/pc_out/inst_valid out.
// Build macro FETCH_PERF_CNT_EN adds perf_bubble_cnt and perf_flush_cnt.
module fetch_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      QDEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] pc_out,
  output logic             inst_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_bubble_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISC
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] qdata_q [QDEPTH];
  logic [WIDTH-1:0] qpc_q   [QDEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_nopush;
  logic [CW-1:0]    cnt_push;
  logic             pop, push, req;
  logic             room_idle, room_ack;

  always_comb begin
    inst_valid = (cnt_q != '0);
    inst       = inst_valid ? qdata_q[rd_q] : '0;
    pc_out     = inst_valid ? qpc_q[rd_q] : '0;
    pop        = inst_valid && !stall;
    // occupancy after this cycle's pop, with and without a push
    cnt_nopush = cnt_q - CW'(pop);
    cnt_push   = cnt_nopush + CW'(1);
    room_idle  = cnt_nopush < CW'(QDEPTH);
    room_ack   = cnt_push < CW'(QDEPTH);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    req     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (branch_taken) begin
          pc_d = branch_target;
        end else if (room_idle) begin
          req     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = imem_ack ? S_IDLE : S_DISC;
        end else if (imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_q + WIDTH'(4);
          state_d = room_ack ? S_WAIT : S_IDLE;
        end
      end
      S_DISC: begin
        req = 1'b1;
        if (branch_taken) pc_d = branch_target;
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // address is frozen for the life of a request, even in DISCARD
    addr_d = (state_d == S_WAIT) ? pc_d : addr_q;
  end

  assign imem_req  = req && rst;
  assign imem_addr = (state_q == S_IDLE) ? pc_q : addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      if (branch_taken) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + PW'(1);
        if (pop)  rd_q <= rd_q + PW'(1);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      qdata_q[wr_q] <= imem_rdata;
      qpc_q[wr_q]   <= pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  localparam int unsigned DW = CW + 1;

  logic [31:0]   bub_q, fl_q;
  logic [DW-1:0] drop_n;
  logic          rsp_drop;
  logic [32:0]   fl_sum;

  always_comb begin
    rsp_drop = imem_ack &&
               (state_q == S_DISC ||
                (state_q == S_WAIT && branch_taken));
    drop_n   = (branch_taken ? {1'b0, cnt_q} : '0) + DW'(rsp_drop);
    fl_sum   = {1'b0, fl_q} + 33'(drop_n);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bub_q <= '0;
      fl_q  <= '0;
    end else begin
      if (!inst_valid && bub_q != '1) bub_q <= bub_q + 32'd1;
      fl_q <= fl_sum[32] ? '1 : fl_sum[31:0];
    end
  end

  assign perf_bubble_cnt = bub_q;
  assign perf_flush_cnt  = fl_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the hybrid ARM/MIPS pipeline. It sits directly upstream of Decode and supplies the 32-bit instruction word and its PC to it. The block owns the PC register and issues one request at a time to instruction memory over a req/ack handshake. Fetched words are buffered in a small instruction queue. It supports stall from the hazard unit and redirect on a taken branch.

Parameters:
WIDTH, 32, data and address width; matches the Decode width.
RESET_PC, 32'h0, PC value loaded on reset.
QDEPTH, 2, instruction queue entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
imem_req  out  1  instruction memory request; held high until acked.
imem_addr  out  WIDTH  request address; stable while imem_req is high.
imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
imem_rdata  in  WIDTH  returned instruction word.
stall  in  1  Decode cannot accept an instruction this cycle.
branch_taken  in  1  redirect request from the branch logic.
branch_target  in  WIDTH  new PC, valid when branch_taken is high.
inst  out  WIDTH  instruction to Decode; 0 (bubble) when inst_valid is low.
pc_out  out  WIDTH  address of inst.
inst_valid  out  1  queue head is valid.

Behaviour:
- Reset (rst low at an edge):
  - fetch_pc = RESET_PC; queue emptied.
  - imem_req = 0, inst_valid = 0, inst = 0, pc_out = 0.
  - FSM goes to IDLE, and any in-flight response is forgotten.
  - Reset overrides every other input in the same cycle.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response will be kept.
  - DISCARD: request outstanding, response will be dropped.
- IDLE -> WAIT when the queue has room (count < QDEPTH) and branch_taken is low.
  - imem_req rises in that same cycle, combinationally from state.
  - imem_addr = fetch_pc.
- WAIT on imem_ack:
  - push {imem_rdata, fetch_pc} into the queue.
  - fetch_pc += 4, wrapping modulo 2^WIDTH.
  - If the queue still has room after the push and the pop, go straight back to WAIT with a new request. Back-to-back fetches with zero idle cycles are allowed.
  - Otherwise go to IDLE.
- Room is evaluated as count - pop + push < QDEPTH, using this cycle's pop.
- Dequeue (pop): happens when inst_valid = 1 and stall = 0. The head advances at the edge.
- inst / pc_out / inst_valid are driven combinationally from the queue head.
  - A word acked in cycle N is visible to Decode in cycle N+1 at the earliest.
- Redirect (branch_taken = 1 at an edge), priority over stall:
  - Queue flushed; fetch_pc = branch_target.
  - From WAIT without ack in the same cycle: go to DISCARD.
  - From WAIT with ack in the same cycle: drop that word, go to IDLE.
  - From IDLE: stay IDLE; the next cycle issues at branch_target.
- DISCARD on imem_ack: drop the word, go to IDLE. A new branch_taken while in DISCARD only updates fetch_pc.
- imem_req stays high while in WAIT or DISCARD; the address never changes mid-request.
- Full queue with stall held: no new requests are issued, and the head is held indefinitely.
- Simultaneous push and pop while full: not possible, because no request is outstanding when count = QDEPTH.
- Simultaneous push and pop otherwise: count unchanged.
- Queue pointers wrap modulo QDEPTH.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds output perf_bubble_cnt (32 bits), counting cycles with inst_valid = 0.
  - Adds output perf_flush_cnt (32 bits), counting dropped words, whether flushed queue entries or discarded responses.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. Reset with RESET_PC = 32'h0, memory acks 1 cycle after req, stall = 0 -> addresses 0, 4, 8, ... issued back-to-back. First inst_valid at cycle 2 after reset release, with pc_out = 0 and inst = word at 0.
2. stall held high for 10 cycles with QDEPTH = 2 -> exactly 2 words queued, then imem_req stays 0. inst and pc_out hold at the head. On stall release, the head advances each cycle and fetching resumes.
3. branch_taken with target 32'h100 while a request to 32'h8 is outstanding, ack 3 cycles later -> that word is dropped and inst_valid goes low. The next request is to 32'h100, and pc_out = 32'h100 is the next valid output.
4. branch_taken in the same cycle as imem_ack -> the acked word is not enqueued. The next request is to branch_target in the following cycle.
5. rst asserted low while in WAIT, then a stray imem_ack arrives after release -> queue empty, first request at RESET_PC. The stale ack must not corrupt state.
6. With FETCH_PERF_CNT_EN defined: run scenario 3 -> perf_flush_cnt = 1 (one discarded response; the queue was empty at the redirect). perf_bubble_cnt increments only on cycles where inst_valid = 0.
